// File: rtl/dmi_cmd_sequencer.sv
// DMI command sequencer: FIFO-fed debug-transport master that issues one request at a
// time, retries busy responses with backoff, times out, and reports a terminal exit code.
module dmi_cmd_sequencer #(
  parameter int ADDR_BITS      = 7,
  parameter int DATA_BITS      = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int MAX_RETRIES    = 8,
  parameter int BACKOFF_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [1:0]           cmd_op,
  input  logic [DATA_BITS-1:0] cmd_data,
  input  logic                 cmd_last,
  output logic                 debug_req_valid,
  input  logic                 debug_req_ready,
  output logic [ADDR_BITS-1:0] debug_req_bits_addr,
  output logic [1:0]           debug_req_bits_op,
  output logic [DATA_BITS-1:0] debug_req_bits_data,
  input  logic                 debug_resp_valid,
  output logic                 debug_resp_ready,
  input  logic [1:0]           debug_resp_bits_resp,
  input  logic [DATA_BITS-1:0] debug_resp_bits_data,
  output logic                 rdata_valid,
  output logic [ADDR_BITS-1:0] rdata_addr,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 busy,
  output logic [31:0]          exit
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int BW = $clog2(BACKOFF_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(CMD_DEPTH);
  localparam logic [RW-1:0] RTY_LIM = RW'(MAX_RETRIES);
  localparam logic [BW-1:0] BO_LAST = BW'(BACKOFF_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0]  OP_RD      = 2'd1;
  localparam logic [1:0]  OP_RSV     = 2'd3;
  localparam logic [31:0] EXIT_PASS  = 32'd1;
  localparam logic [31:0] EXIT_DMERR = 32'd3;
  localparam logic [31:0] EXIT_RETRY = 32'd5;
  localparam logic [31:0] EXIT_TMO   = 32'd7;
  localparam logic [31:0] EXIT_ILL   = 32'd9;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_BACKOFF, S_DONE, S_FAIL} state_e;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [1:0]           op;
    logic [DATA_BITS-1:0] data;
    logic                 last;
  } cmd_t;

  cmd_t mem_q [CMD_DEPTH];
  cmd_t cmd_in, cur_q, cur_d;
  state_e state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [BW-1:0] bo_q, bo_d;
  logic [TW-1:0] tmo_q, tmo_d, tmo_nxt;
  logic [31:0] exit_q, exit_d;
  logic req_valid_q, req_valid_d, resp_ready_q, resp_ready_d;
  logic rdata_valid_q, rdata_valid_d, cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic [ADDR_BITS-1:0] rdata_addr_q, rdata_addr_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic push, pop, tmo_run, tmo_hit, term_d;

  assign cmd_in = '{addr: cmd_addr, op: cmd_op, data: cmd_data, last: cmd_last};

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    retry_d       = retry_q;
    bo_d          = bo_q;
    exit_d        = exit_q;
    req_valid_d   = req_valid_q;
    resp_ready_d  = resp_ready_q;
    rdata_valid_d = 1'b0;
    rdata_d       = rdata_q;
    rdata_addr_d  = rdata_addr_q;
    push          = cmd_valid && cmd_ready_q;
    pop           = 1'b0;
    // The timer only runs while a request is actually visible or a response is awaited.
    tmo_run       = (state_q == S_REQ && req_valid_q) || (state_q == S_RESP);
    tmo_nxt       = tmo_q + TW'(1);
    tmo_hit       = tmo_run && (tmo_nxt == TMO_LIM);
    tmo_d         = tmo_run ? tmo_nxt : tmo_q;
    case (state_q)
      S_IDLE: if (count_q != '0) begin
        pop     = 1'b1;
        cur_d   = mem_q[rd_ptr_q];
        retry_d = '0;
        tmo_d   = '0;
        if (mem_q[rd_ptr_q].op == OP_RSV) begin
          state_d = S_FAIL;
          exit_d  = EXIT_ILL;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (req_valid_q && debug_req_ready) begin
          state_d      = S_RESP;
          req_valid_d  = 1'b0;
          resp_ready_d = 1'b1;
        end else if (tmo_hit) begin
          state_d     = S_FAIL;
          req_valid_d = 1'b0;
          exit_d      = EXIT_TMO;
        end else begin
          req_valid_d = 1'b1;
        end
      end
      S_RESP: begin
        if (debug_resp_valid && resp_ready_q) begin
          resp_ready_d = 1'b0;
          case (debug_resp_bits_resp)
            2'd0: begin
              if (cur_q.op == OP_RD) begin
                rdata_valid_d = 1'b1;
                rdata_d       = debug_resp_bits_data;
                rdata_addr_d  = cur_q.addr;
              end
              if (cur_q.last) begin
                state_d = S_DONE;
                exit_d  = EXIT_PASS;
              end else begin
                state_d = S_IDLE;
              end
            end
            2'd3: begin
              retry_d = retry_q + RW'(1);
              if (retry_d == RTY_LIM) begin
                state_d = S_FAIL;
                exit_d  = EXIT_RETRY;
              end else begin
                state_d = S_BACKOFF;
                bo_d    = '0;
              end
            end
            default: begin
              state_d = S_FAIL;
              exit_d  = EXIT_DMERR;
            end
          endcase
        end else if (tmo_hit) begin
          state_d      = S_FAIL;
          resp_ready_d = 1'b0;
          exit_d       = EXIT_TMO;
        end
      end
      S_BACKOFF: begin
        bo_d = bo_q + BW'(1);
        if (bo_q == BO_LAST) begin
          state_d = S_REQ;
          bo_d    = '0;
          tmo_d   = '0;
        end
      end
      default: ;
    endcase
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    // Ready and busy are registered from next-state values so they track the FIFO exactly.
    term_d      = (state_d == S_DONE) || (state_d == S_FAIL);
    cmd_ready_d = (count_d != DEPTH_C) && !term_d;
    busy_d      = !term_d && ((count_d != '0) || (state_d != S_IDLE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CMD_DEPTH; i++) mem_q[i] <= '0;
      state_q       <= S_IDLE;
      cur_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      retry_q       <= '0;
      bo_q          <= '0;
      tmo_q         <= '0;
      exit_q        <= '0;
      req_valid_q   <= 1'b0;
      resp_ready_q  <= 1'b0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
      rdata_addr_q  <= '0;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= cmd_in;
      state_q       <= state_d;
      cur_q         <= cur_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      retry_q       <= retry_d;
      bo_q          <= bo_d;
      tmo_q         <= tmo_d;
      exit_q        <= exit_d;
      req_valid_q   <= req_valid_d;
      resp_ready_q  <= resp_ready_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_q       <= rdata_d;
      rdata_addr_q  <= rdata_addr_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign cmd_ready           = cmd_ready_q;
  assign debug_req_valid     = req_valid_q;
  assign debug_req_bits_addr = cur_q.addr;
  assign debug_req_bits_op   = cur_q.op;
  assign debug_req_bits_data = cur_q.data;
  assign debug_resp_ready    = resp_ready_q;
  assign rdata_valid         = rdata_valid_q;
  assign rdata_addr          = rdata_addr_q;
  assign rdata               = rdata_q;
  assign busy                = busy_q;
  assign exit                = exit_q;

endmodule

// File: tb/tb_dmi_cmd_sequencer.sv
// Scoreboard bench for dmi_cmd_sequencer: a script-level reference model fills expectation
// queues, a DM responder plays a response plan, and a monitor pops and compares.
module tb_dmi_cmd_sequencer;
  localparam int AB = 7, DB = 32, DEPTH = 4, MAXR = 8, BO = 4, TMO = 1024;

  typedef struct { logic [AB-1:0] addr; logic [1:0] op; logic [DB-1:0] data; bit last; } cmd_s;
  typedef struct { logic [1:0] code; logic [DB-1:0] data; int delay; } rsp_s;
  typedef struct { logic [AB-1:0] addr; logic [DB-1:0] data; } rd_s;

  logic clk, reset;
  logic cmd_valid, cmd_ready, cmd_last;
  logic [AB-1:0] cmd_addr;
  logic [1:0] cmd_op;
  logic [DB-1:0] cmd_data;
  logic req_valid, req_ready, resp_valid, resp_ready, rdata_valid, busy;
  logic [AB-1:0] req_addr, rdata_addr;
  logic [1:0] req_op, resp_code;
  logic [DB-1:0] req_data, resp_data, rdata;
  logic [31:0] exit_code;

  dmi_cmd_sequencer #(.ADDR_BITS(AB), .DATA_BITS(DB), .CMD_DEPTH(DEPTH), .MAX_RETRIES(MAXR),
                      .BACKOFF_CYCLES(BO), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_last(cmd_last),
    .debug_req_valid(req_valid), .debug_req_ready(req_ready), .debug_req_bits_addr(req_addr),
    .debug_req_bits_op(req_op), .debug_req_bits_data(req_data),
    .debug_resp_valid(resp_valid), .debug_resp_ready(resp_ready),
    .debug_resp_bits_resp(resp_code), .debug_resp_bits_data(resp_data),
    .rdata_valid(rdata_valid), .rdata_addr(rdata_addr), .rdata(rdata),
    .busy(busy), .exit(exit_code));

  initial begin clk = 0; forever #5 clk = ~clk; end

  int checks = 0, failures = 0, cyc = 0, accepted = 0, dm_mode = 0;
  string scn = "init";
  cmd_s script[$], exp_req[$];
  rsp_s plan[$], dm_plan[$];
  rd_s exp_rd[$];
  logic [31:0] exp_exit;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s: got %0h expected %0h", scn, nm, act, exp);
    end
  endtask

  // Reference model: walk the script against the response plan, one request per plan entry.
  function automatic void build_model();
    int pi = 0, busies;
    rsp_s r;
    exp_exit = 0;
    foreach (script[i]) begin
      if (script[i].op == 2'd3) begin exp_exit = 9; return; end
      busies = 0;
      forever begin
        exp_req.push_back(script[i]);
        if (pi >= plan.size()) begin exp_exit = 7; return; end
        r = plan[pi]; pi++;
        if (r.code == 2'd0) begin
          if (script[i].op == 2'd1) exp_rd.push_back('{script[i].addr, r.data});
          break;
        end else if (r.code == 2'd3) begin
          busies++;
          if (busies == MAXR) begin exp_exit = 5; return; end
        end else begin
          exp_exit = 3; return;
        end
      end
      if (script[i].last) begin exp_exit = 1; return; end
    end
  endfunction

  // DM responder
  initial begin
    bit hs_req, hs_rsp, pend;
    rsp_s cur;
    int dly;
    req_ready = 0; resp_valid = 0; resp_code = 0; resp_data = 0; pend = 0; dly = 0;
    forever begin
      @(negedge clk);
      hs_req = reset && req_valid && req_ready;
      hs_rsp = reset && resp_valid && resp_ready;
      @(posedge clk); #1;
      if (!reset) begin pend = 0; resp_valid = 0; req_ready = 0; continue; end
      if (hs_rsp) resp_valid = 0;
      if (hs_req && dm_plan.size() > 0) begin cur = dm_plan.pop_front(); pend = 1; dly = cur.delay; end
      if (pend && !resp_valid) begin
        if (dly == 0) begin resp_valid = 1; resp_code = cur.code; resp_data = cur.data; pend = 0; end
        else dly--;
      end
      req_ready = (dm_mode == 1) ? 1'b1 : (dm_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor
  initial begin
    bit exit_seen, prev_rv, gap_arm;
    int last_rise, gap_cnt;
    cmd_s ec;
    rd_s er;
    exit_seen = 0; prev_rv = 0; gap_arm = 0; last_rise = 0; gap_cnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin exit_seen = 0; prev_rv = 0; gap_arm = 0; continue; end
      if (req_valid && !prev_rv) last_rise = cyc;
      prev_rv = req_valid;
      if (gap_arm) begin
        if (req_valid) begin chk("backoff_gap", 64'(gap_cnt >= BO), 1); gap_arm = 0; end
        else gap_cnt++;
      end
      if (req_valid && req_ready) begin
        chk("req_expected", 64'(exp_req.size() != 0), 1);
        if (exp_req.size() != 0) begin
          ec = exp_req.pop_front();
          chk("req_bits", {req_addr, req_op, req_data}, {ec.addr, ec.op, ec.data});
        end
      end
      if (resp_valid && resp_ready && resp_code == 2'd3) begin gap_arm = 1; gap_cnt = 0; end
      if (rdata_valid) begin
        chk("rd_expected", 64'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) begin
          er = exp_rd.pop_front();
          chk("rdata", {rdata_addr, rdata}, {er.addr, er.data});
        end
      end
      if (exit_code != 0 && !exit_seen) begin
        exit_seen = 1;
        chk("exit", exit_code, exp_exit);
        if (exp_exit == 32'd7) chk("tmo_cycles", 64'(cyc - last_rise), TMO);
      end
    end
  end

  function automatic cmd_s mk(input logic [AB-1:0] a, input logic [1:0] op, input logic [DB-1:0] d, input bit last);
    cmd_s c; c.addr = a; c.op = op; c.data = d; c.last = last; return c;
  endfunction

  function automatic rsp_s mr(input logic [1:0] code, input logic [DB-1:0] d, input int dly);
    rsp_s r; r.code = code; r.data = d; r.delay = dly; return r;
  endfunction

  task automatic start_scn(input string nm);
    scn = nm;
    reset = 0; cmd_valid = 0;
    repeat (2) @(posedge clk);
    exp_req.delete(); exp_rd.delete();
    dm_plan = plan; accepted = 0;
    build_model();
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic push_cmd(input cmd_s c, output bit ok);
    int w = 0;
    ok = 0;
    cmd_valid = 1; cmd_addr = c.addr; cmd_op = c.op; cmd_data = c.data; cmd_last = c.last;
    while (w < 3000) begin
      @(negedge clk);
      if (cmd_ready) begin @(posedge clk); #1; ok = 1; break; end
      if (exit_code != 0) break;
      w++;
    end
    cmd_valid = 0;
  endtask

  task automatic push_all(input int from);
    bit ok;
    for (int i = from; i < script.size(); i++) begin
      push_cmd(script[i], ok);
      if (!ok) begin chk("push_stuck", 64'(exit_code != 0), 1); break; end
      accepted++;
    end
  endtask

  task automatic finish_scn();
    int n = 0;
    while (exit_code == 0 && n < 5000) begin @(negedge clk); n++; end
    chk("exit_seen", 64'(exit_code != 0), 1);
    repeat (3) @(negedge clk);
    chk("term_outputs", {req_valid, resp_ready, cmd_ready, busy}, 0);
    chk("exit_hold", exit_code, exp_exit);
    chk("req_left", 64'(exp_req.size()), 0);
    chk("rd_left", 64'(exp_rd.size()), 0);
  endtask

  initial begin
    bit ok;
    int n, r;
    reset = 0; cmd_valid = 0; cmd_addr = 0; cmd_op = 0; cmd_data = 0; cmd_last = 0;
    #12;
    chk("reset_outputs", {cmd_ready, req_valid, resp_ready, rdata_valid, busy, exit_code}, 0);

    // Write then read, DM always ready, latency from push to request
    script = '{mk(7'h10, 2'd2, 32'h1, 0), mk(7'h11, 2'd1, 32'h0, 1)};
    plan = '{mr(2'd0, 32'h0, 0), mr(2'd0, 32'hDEADBEEF, 0)};
    dm_mode = 1;
    start_scn("wr_rd");
    chk("ready_after_reset", cmd_ready, 1);
    push_cmd(script[0], ok);
    @(negedge clk); @(negedge clk);
    chk("lat_pre", req_valid, 0);
    @(negedge clk);
    chk("lat_req", req_valid, 1);
    push_all(1);
    finish_scn();

    // FIFO fill while DM stalls requests
    script.delete();
    for (int i = 0; i < 6; i++) script.push_back(mk(7'(8'h20 + i), 2'd2, $urandom, i == 5));
    plan.delete();
    for (int i = 0; i < 6; i++) plan.push_back(mr(2'd0, $urandom, $urandom_range(0, 3)));
    dm_mode = 2;
    start_scn("fifo_full");
    fork
      push_all(0);
      begin
        repeat (25) @(negedge clk);
        chk("stall_accepted", 64'(accepted), DEPTH + 1);
        chk("stall_ready", cmd_ready, 0);
        dm_mode = 0;
      end
    join
    finish_scn();

    // Busy twice then ok
    script = '{mk(7'h30, 2'd2, 32'hA5A5_0001, 1)};
    plan = '{mr(2'd3, 0, 0), mr(2'd3, 0, 1), mr(2'd0, 0, 0)};
    start_scn("busy2");
    push_all(0);
    finish_scn();

    // Busy exhausts retries
    script = '{mk(7'h31, 2'd1, 32'h0, 1)};
    plan.delete();
    for (int i = 0; i < MAXR + 2; i++) plan.push_back(mr(i < MAXR ? 2'd3 : 2'd0, 32'h5, 0));
    start_scn("busy_max");
    push_all(0);
    finish_scn();

    // DM never responds
    script = '{mk(7'h40, 2'd2, 32'h1234, 1)};
    plan.delete();
    start_scn("timeout");
    push_all(0);
    finish_scn();

    // Reserved op
    script = '{mk(7'h41, 2'd3, 32'h0, 1)};
    start_scn("illegal_op");
    push_all(0);
    finish_scn();

    // DM error
    script = '{mk(7'h42, 2'd1, 32'h0, 1)};
    plan = '{mr(2'd2, 32'h0, 0)};
    start_scn("dm_err");
    push_all(0);
    finish_scn();

    // Reset while waiting for a response, then a clean script
    script = '{mk(7'h43, 2'd1, 32'h0, 1)};
    plan.delete();
    start_scn("reset_mid");
    push_all(0);
    n = 0;
    while (!resp_ready && n < 100) begin @(negedge clk); n++; end
    chk("reached_resp", resp_ready, 1);
    #2 reset = 0;
    #1;
    chk("async_ctl", {cmd_ready, req_valid, req_addr, req_op, resp_ready, rdata_valid, rdata_addr, busy, exit_code}, 0);
    chk("async_data", {req_data, rdata}, 0);
    script = '{mk(7'h44, 2'd2, 32'h77, 0), mk(7'h45, 2'd1, 32'h0, 1)};
    plan = '{mr(2'd0, 32'h0, 1), mr(2'd0, 32'hCAFE_F00D, 2)};
    start_scn("after_reset");
    push_all(0);
    finish_scn();

    // Randomized scripts and response plans
    for (int s = 0; s < 10; s++) begin
      int len;
      logic [1:0] op;
      len = $urandom_range(1, 5);
      script.delete();
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 99);
        op = (r < 5) ? 2'd0 : (r < 50) ? 2'd1 : (r < 96) ? 2'd2 : 2'd3;
        script.push_back(mk(7'($urandom), op, $urandom, i == len - 1));
      end
      plan.delete();
      n = $urandom_range(3, 14);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 99);
        plan.push_back(mr((r < 78) ? 2'd0 : (r < 93) ? 2'd3 : (r < 97) ? 2'd2 : 2'd1,
                          $urandom, $urandom_range(0, 4)));
      end
      start_scn($sformatf("rand%0d", s));
      push_all(0);
      finish_scn();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
